// File: rtl/pe_cfg_seq.sv
// pe_cfg_seq: streams XID/YID scan chains from a word stream, loads LN config, then pulses PE enable.
//   clk/rst                       : clock, asynchronous active-high reset
//   start_i/abort_i               : start pulse (taken in IDLE only), abort to IDLE from any state
//   layer_config_i/ln_config_i/pe_mask_i : captured when start is accepted
//   cfg_valid_i/cfg_ready_o/cfg_data_i   : ID word stream, {opsum, ipsum, ifmap, filter} with filter in the LSBs
//   set_XID_o + *_XID_scan_in_o   : X scan shift, one per accepted word in LOAD_X
//   set_YID_o + *_YID_scan_in_o   : Y scan shift, one per accepted word in LOAD_Y
//   set_LN_o/LN_config_in_o       : one-cycle LN load
//   PE_en_o/PE_config_o           : one-cycle enable mask, captured layer config
//   busy_o/done_o                 : not idle, one-cycle completion pulse
module pe_cfg_seq #(
    parameter int NUMS_PE_ROW = 6,
    parameter int NUMS_PE_COL = 8,
    parameter int XID_BITS    = 4,
    parameter int YID_BITS    = 3,
    parameter int CONFIG_SIZE = 10
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start_i,
    input  logic                               abort_i,
    input  logic [CONFIG_SIZE-1:0]             layer_config_i,
    input  logic [NUMS_PE_ROW-2:0]             ln_config_i,
    input  logic [NUMS_PE_ROW*NUMS_PE_COL-1:0] pe_mask_i,
    input  logic                               cfg_valid_i,
    output logic                               cfg_ready_o,
    input  logic [4*XID_BITS-1:0]              cfg_data_i,
    output logic                               set_XID_o,
    output logic [XID_BITS-1:0]                filter_XID_scan_in_o,
    output logic [XID_BITS-1:0]                ifmap_XID_scan_in_o,
    output logic [XID_BITS-1:0]                ipsum_XID_scan_in_o,
    output logic [XID_BITS-1:0]                opsum_XID_scan_in_o,
    output logic                               set_YID_o,
    output logic [YID_BITS-1:0]                filter_YID_scan_in_o,
    output logic [YID_BITS-1:0]                ifmap_YID_scan_in_o,
    output logic [YID_BITS-1:0]                ipsum_YID_scan_in_o,
    output logic [YID_BITS-1:0]                opsum_YID_scan_in_o,
    output logic                               set_LN_o,
    output logic [NUMS_PE_ROW-2:0]             LN_config_in_o,
    output logic [NUMS_PE_ROW*NUMS_PE_COL-1:0] PE_en_o,
    output logic [CONFIG_SIZE-1:0]             PE_config_o,
    output logic                               busy_o,
    output logic                               done_o
);
    localparam int NPE = NUMS_PE_ROW * NUMS_PE_COL;
    typedef enum logic [2:0] {IDLE, LOAD_X, LOAD_Y, LOAD_LN, ENABLE} state_t;
    state_t                 state_q, state_d;
    logic [5:0]             cnt_q, cnt_d;
    logic [CONFIG_SIZE-1:0] cfg_q, cfg_d;
    logic [NUMS_PE_ROW-2:0] ln_q, ln_d;
    logic [NPE-1:0]         mask_q, mask_d;
    logic                   hs, last;
    // abort kills every strobe in the cycle it is seen
    assign cfg_ready_o = (state_q == LOAD_X || state_q == LOAD_Y) && !abort_i;
    assign hs          = cfg_valid_i && cfg_ready_o;
    assign last        = cnt_q == ((state_q == LOAD_X) ? 6'(NPE - 1) : 6'(NUMS_PE_ROW - 1));
    assign set_XID_o   = hs && state_q == LOAD_X;
    assign set_YID_o   = hs && state_q == LOAD_Y;
    assign set_LN_o    = state_q == LOAD_LN && !abort_i;
    assign done_o      = state_q == ENABLE && !abort_i;
    assign busy_o      = state_q != IDLE;
    assign PE_en_o        = done_o ? mask_q : '0;
    assign PE_config_o    = cfg_q;
    assign LN_config_in_o = set_LN_o ? ln_q : '0;
    assign filter_XID_scan_in_o = set_XID_o ? cfg_data_i[0*XID_BITS +: XID_BITS] : '0;
    assign ifmap_XID_scan_in_o  = set_XID_o ? cfg_data_i[1*XID_BITS +: XID_BITS] : '0;
    assign ipsum_XID_scan_in_o  = set_XID_o ? cfg_data_i[2*XID_BITS +: XID_BITS] : '0;
    assign opsum_XID_scan_in_o  = set_XID_o ? cfg_data_i[3*XID_BITS +: XID_BITS] : '0;
    assign filter_YID_scan_in_o = set_YID_o ? cfg_data_i[0*XID_BITS +: YID_BITS] : '0;
    assign ifmap_YID_scan_in_o  = set_YID_o ? cfg_data_i[1*XID_BITS +: YID_BITS] : '0;
    assign ipsum_YID_scan_in_o  = set_YID_o ? cfg_data_i[2*XID_BITS +: YID_BITS] : '0;
    assign opsum_YID_scan_in_o  = set_YID_o ? cfg_data_i[3*XID_BITS +: YID_BITS] : '0;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cfg_d   = cfg_q;
        ln_d    = ln_q;
        mask_d  = mask_q;
        if (abort_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: if (start_i) begin
                    state_d = LOAD_X;
                    cnt_d   = '0;
                    cfg_d   = layer_config_i;
                    ln_d    = ln_config_i;
                    mask_d  = pe_mask_i;
                end
                LOAD_X, LOAD_Y: if (hs) begin
                    cnt_d = last ? '0 : cnt_q + 6'd1;
                    if (last) state_d = (state_q == LOAD_X) ? LOAD_Y : LOAD_LN;
                end
                LOAD_LN: state_d = ENABLE;
                default: state_d = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cfg_q   <= '0;
            ln_q    <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cfg_q   <= cfg_d;
            ln_q    <= ln_d;
            mask_q  <= mask_d;
        end
    end
endmodule

// File: tb/tb_pe_cfg_seq.sv
// tb_pe_cfg_seq: directed bench for pe_cfg_seq with hand-computed latencies and field values.
module tb_pe_cfg_seq;
    logic        clk = 1'b0, rst = 1'b1, start_i = 1'b0, abort_i = 1'b0, cfg_valid_i = 1'b0;
    logic [9:0]  layer_config_i = '0;
    logic [4:0]  ln_config_i = '0;
    logic [47:0] pe_mask_i = '0;
    logic [15:0] cfg_data_i;
    logic        cfg_ready_o, set_XID_o, set_YID_o, set_LN_o, busy_o, done_o;
    logic [3:0]  fx, ix, px, ox;
    logic [2:0]  fy, iy, py, oy;
    logic [4:0]  LN_config_in_o;
    logic [47:0] PE_en_o;
    logic [9:0]  PE_config_o;
    int n_cmp = 0, n_bad = 0;
    int w = 0, nx = 0, ny = 0, nln = 0;
    logic [4:0] ln_seen = '0;

    pe_cfg_seq dut (
        .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
        .layer_config_i(layer_config_i), .ln_config_i(ln_config_i), .pe_mask_i(pe_mask_i),
        .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o), .cfg_data_i(cfg_data_i),
        .set_XID_o(set_XID_o), .filter_XID_scan_in_o(fx), .ifmap_XID_scan_in_o(ix),
        .ipsum_XID_scan_in_o(px), .opsum_XID_scan_in_o(ox),
        .set_YID_o(set_YID_o), .filter_YID_scan_in_o(fy), .ifmap_YID_scan_in_o(iy),
        .ipsum_YID_scan_in_o(py), .opsum_YID_scan_in_o(oy),
        .set_LN_o(set_LN_o), .LN_config_in_o(LN_config_in_o),
        .PE_en_o(PE_en_o), .PE_config_o(PE_config_o), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // word w carries filter=w, ifmap=w^A, ipsum=w+5, opsum=~w (4-bit)
    function automatic logic [15:0] xexp(input int k);
        logic [3:0] b;
        b = 4'(k);
        return {~b, b + 4'd5, b ^ 4'hA, b};
    endfunction
    function automatic logic [11:0] yexp(input int k);
        logic [15:0] x;
        x = xexp(k);
        return {x[14:12], x[10:8], x[6:4], x[2:0]};
    endfunction
    assign cfg_data_i = xexp(w);

    always @(negedge clk) begin
        if (set_XID_o || set_YID_o) check("shift_needs_valid", cfg_valid_i, 1);
        if (set_XID_o) begin
            check("xid_fields", {ox, px, ix, fx}, xexp(w));
            nx++;
            w++;
        end
        if (set_YID_o) begin
            check("yid_fields", {oy, py, iy, fy}, yexp(w));
            ny++;
            w++;
        end
        if (set_LN_o) begin
            nln++;
            ln_seen = LN_config_in_o;
        end
        if (!done_o) check("pe_en_off", PE_en_o, 0);
    end

    // entered and left at posedge+1; lat = cycle of done counting the start cycle as 1, 0 if none
    task automatic run(input bit stall, input int restart_at, input int abort_at, input int maxc,
                       input logic [47:0] exp_mask, input logic [9:0] exp_cfg,
                       output int lat, output logic busy_ab);
        lat = 0;
        busy_ab = 1'b1;
        start_i = 1'b1;
        for (int c = 1; c <= maxc; c++) begin
            cfg_valid_i = stall ? c[0] : 1'b1;
            abort_i = (c == abort_at);
            if (c == restart_at) begin
                start_i = 1'b1;
                layer_config_i = 10'h155;
            end
            @(negedge clk);
            if (c == abort_at) begin
                check("abort_ready", cfg_ready_o, 0);
                check("abort_sety", set_YID_o, 0);
            end
            if (c == abort_at + 1) busy_ab = busy_o;
            if (done_o) begin
                lat = c;
                check("en_mask", PE_en_o, exp_mask);
                check("en_cfg", PE_config_o, exp_cfg);
                break;
            end
            @(posedge clk);
            #1;
            start_i = 1'b0;
            abort_i = 1'b0;
        end
        start_i = 1'b0;
        abort_i = 1'b0;
        if (lat != 0) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, nx0, ny0, nln0, d1, d2;
        logic bab;
        #3;
        check("rst_ctrl", {cfg_ready_o, set_XID_o, set_YID_o, set_LN_o, busy_o, done_o}, 0);
        check("rst_pe", {PE_en_o, PE_config_o, LN_config_in_o}, 0);
        check("rst_scan", {ox, px, ix, fx, oy, py, iy, fy}, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("idle_busy", busy_o, 0);

        // nominal
        layer_config_i = 10'h3FF; ln_config_i = 5'b10110; pe_mask_i = '1;
        nx0 = nx; ny0 = ny; nln0 = nln;
        run(0, 0, 0, 200, '1, 10'h3FF, lat, bab);
        check("nom_lat", lat, 57);
        check("nom_nx", nx - nx0, 48);
        check("nom_ny", ny - ny0, 6);
        check("nom_nln", nln - nln0, 1);
        check("nom_ln", ln_seen, 5'b10110);
        check("nom_busy_after", busy_o, 0);

        // stalls
        layer_config_i = 10'h0C3; ln_config_i = 5'b01001; pe_mask_i = 48'h0123_4567_89AB;
        nx0 = nx; ny0 = ny; nln0 = nln;
        run(1, 0, 0, 300, 48'h0123_4567_89AB, 10'h0C3, lat, bab);
        check("stall_lat", lat, 111);
        check("stall_nx", nx - nx0, 48);
        check("stall_ny", ny - ny0, 6);
        check("stall_ln", ln_seen, 5'b01001);

        // start while busy
        layer_config_i = 10'h2A5; pe_mask_i = 48'hF0F0_0000_FFFF;
        run(0, 20, 0, 200, 48'hF0F0_0000_FFFF, 10'h2A5, lat, bab);
        check("restart_lat", lat, 57);
        layer_config_i = 10'h2A5;

        // abort on the 4th Y word (cycle 53)
        nx0 = nx; ny0 = ny; nln0 = nln;
        run(0, 0, 53, 80, '0, 10'h0, lat, bab);
        check("abort_nodone", lat, 0);
        check("abort_busy", bab, 0);
        check("abort_ny", ny - ny0, 3);
        check("abort_nln", nln - nln0, 0);
        layer_config_i = 10'h111; pe_mask_i = 48'h8000_0000_0001;
        nx0 = nx; ny0 = ny;
        run(0, 0, 0, 200, 48'h8000_0000_0001, 10'h111, lat, bab);
        check("post_abort_lat", lat, 57);
        check("post_abort_nx", nx - nx0, 48);
        check("post_abort_ny", ny - ny0, 6);

        // back-to-back with start held high
        d1 = 0; d2 = 0;
        start_i = 1'b1; cfg_valid_i = 1'b1;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (done_o) begin
                if (d1 == 0) d1 = c;
                else d2 = c;
            end
            if (d2 != 0) break;
            @(posedge clk);
            #1;
        end
        start_i = 1'b0;
        @(posedge clk);
        #1;
        check("b2b_done1", d1, 57);
        check("b2b_done2", d2, 114);

        // async reset at word 30 of LOAD_X
        nx0 = nx;
        start_i = 1'b1; cfg_valid_i = 1'b1;
        repeat (31) begin
            @(posedge clk);
            #1;
            start_i = 1'b0;
        end
        check("pre_rst_nx", nx - nx0, 30);
        #2;
        rst = 1'b1;
        #1;
        check("arst_ctrl", {cfg_ready_o, set_XID_o, set_YID_o, set_LN_o, busy_o, done_o}, 0);
        check("arst_pe", {PE_en_o, PE_config_o, LN_config_in_o}, 0);
        check("arst_scan", {ox, px, ix, fx, oy, py, iy, fy}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        nx0 = nx; ny0 = ny;
        layer_config_i = 10'h0AA; pe_mask_i = 48'h0000_FFFF_0000;
        run(0, 0, 0, 200, 48'h0000_FFFF_0000, 10'h0AA, lat, bab);
        check("rst_run_lat", lat, 57);
        check("rst_run_nx", nx - nx0, 48);
        check("rst_run_ny", ny - ny0, 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pe_cfg_seq.md
# pe_cfg_seq

Configuration sequencer for the PE array. On a start command it streams the XID and YID scan chains of the four networks from a word stream: the filter, ifmap and ipsum GINs and the opsum GON. It then loads the local-network (LN) configuration and issues a single-cycle PE enable with the layer configuration. It sits between the top-level controller / config DMA and the PE array's scan-chain and controller inputs.

## Interface
- NUMS_PE_ROW, 6, PE rows
- NUMS_PE_COL, 8, PE columns
- XID_BITS, 4, X ID width
- YID_BITS, 3, Y ID width
- CONFIG_SIZE, 10, PE_config width; MSB is the depthwise flag

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  start pulse; sampled only in IDLE
- abort  in  1  return to IDLE from any state
- layer_config  in  CONFIG_SIZE  latched on accepted start
- ln_config  in  NUMS_PE_ROW-1  latched on accepted start
- pe_mask  in  NUMS_PE_ROW*NUMS_PE_COL  latched on accepted start
- cfg_valid  in  1  ID word valid
- cfg_ready  out  1  ID word accepted
- cfg_data  in  4*XID_BITS  packed IDs {opsum, ipsum, ifmap, filter}, filter in the LSBs
- set_XID  out  1  X scan shift
- filter/ifmap/ipsum/opsum_XID_scan_in  out  XID_BITS each
- set_YID  out  1  Y scan shift
- filter/ifmap/ipsum/opsum_YID_scan_in  out  YID_BITS each
- set_LN  out  1  LN load strobe
- LN_config_in  out  NUMS_PE_ROW-1
- PE_en  out  NUMS_PE_ROW*NUMS_PE_COL
- PE_config  out  CONFIG_SIZE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse

## Operation
States: IDLE → LOAD_X → LOAD_Y → LOAD_LN → ENABLE → IDLE.

- **IDLE**
  - start=1 latches layer_config, ln_config and pe_mask.
  - Clears the word counter and goes to LOAD_X.
- **LOAD_X**
  - cfg_ready=1.
  - Each cfg_valid&cfg_ready cycle asserts set_XID combinationally. The four XID scan outputs equal the corresponding cfg_data fields in that same cycle.
  - The counter increments per handshake.
  - After NUMS_PE_ROW*NUMS_PE_COL (48) handshakes: counter clears, go to LOAD_Y.
- **LOAD_Y**
  - Same handshake behaviour, using set_YID.
  - Field k is cfg_data[k*XID_BITS +: YID_BITS]; upper bits are ignored.
  - After NUMS_PE_ROW (6) handshakes, go to LOAD_LN.
- **LOAD_LN**
  - set_LN=1 and LN_config_in = latched ln_config for one cycle.
  - Go to ENABLE.
- **ENABLE**
  - PE_en = latched pe_mask and PE_config = latched layer_config for one cycle.
  - done=1 for that cycle; go to IDLE.

Rules in all states:
- Outside ENABLE, PE_en=0. PE_config holds its latched value at all times.
- set_XID/set_YID are never asserted without a handshake. A stall (cfg_valid=0) freezes the counter and the scan chains.
- Words are consumed first-to-last in scan order. The first word accepted ends up at the far end of the chain.
- start outside IDLE is ignored.
- abort has priority over every transition:
  - next state is IDLE, the counter is cleared, and cfg_ready, set_* and PE_en are deasserted in the abort cycle;
  - done is not pulsed;
  - partially shifted chains are left as-is;
  - abort and start in the same IDLE cycle means abort wins and the block stays in IDLE.
- The counter is 6 bits wide. Its terminal count is compared on the handshake cycle and it never wraps.

## Timing
- Reset values:
  - state IDLE, counter 0;
  - cfg_ready, set_XID, set_YID, set_LN, busy and done all 0;
  - all scan outputs 0, LN_config_in 0, PE_en 0, PE_config 0.
- busy rises the cycle after the start is accepted.
- cfg_ready is combinational from state only. It does not depend on cfg_valid.
- With cfg_valid held high, minimum start-to-done latency is 1 + 48 + 6 + 1 + 1 = 57 cycles. done is asserted in cycle 57 after the start edge.
- The cycle after ENABLE is IDLE, so a start in that cycle is accepted: back-to-back operation.
- A reset mid-operation immediately forces the reset values. No output glitches beyond the asynchronous clear.

## Test plan
- **Nominal run.** layer_config=0x3FF, ln_config=5'b10110, pe_mask all-ones, 54 words with cfg_valid always 1 and filter XID = word index.
  - 48 set_XID pulses with filter_XID 0..15 repeating (4-bit), then 6 set_YID pulses.
  - set_LN with LN_config_in=10110.
  - One PE_en=all-ones cycle with PE_config=0x3FF; done at cycle 57.
- **Stalls.** cfg_valid toggles every other cycle.
  - Same shifted sequence; set_XID count stays 48 and set_YID count stays 6.
  - done at cycle 111; no shift on cycles where cfg_valid=0.
- **Abort.** Abort during LOAD_Y after 3 Y words.
  - Next cycle is IDLE; busy=0, done never pulses, set_LN never asserts.
  - A following start runs a full 57-cycle sequence.
- **Start while busy.** start re-pulsed at cycle 20 with different layer_config.
  - Ignored; PE_config at ENABLE equals the first value.
- **Back-to-back.** start held high continuously.
  - Second run begins the cycle after done; two done pulses 57 cycles apart.
- **Async reset.** rst asserted in LOAD_X at word 30, deasserted, then start.
  - All outputs are 0 during reset; the counter restarts and exactly 48 XID shifts follow.
